// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared constants, input FSM states and round-robin pick helper for router_16x16
package router_pkg;

  localparam int NPORTS = 16;
  localparam int ADDR_W = 4;

  typedef enum logic [1:0] {IDLE, ADDR, FWD, DROP} in_state_e;

  // Returns {valid, index} of the first set request at or after ptr, wrapping mod NPORTS.
  function automatic logic [ADDR_W:0] rr_pick(input logic [NPORTS-1:0] req,
                                              input logic [ADDR_W-1:0] ptr);
    logic [ADDR_W:0]   res;
    logic [ADDR_W-1:0] idx;
    res = '0;
    for (int k = NPORTS - 1; k >= 0; k--) begin
      idx = ptr + ADDR_W'(k);
      if (req[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

endpackage

// File: rtl/router_16x16_if.sv
// rtl/router_16x16_if.sv - serial port bundle for the 16x16 packet switch
interface router_16x16_if;
  logic [15:0] din;
  logic [15:0] frame_n;
  logic [15:0] valid_n;
  logic [15:0] dout;
  logic [15:0] valido_n;
  logic [15:0] frameo_n;

  modport master (output din, frame_n, valid_n, input dout, valido_n, frameo_n);
  modport slave  (input din, frame_n, valid_n, output dout, valido_n, frameo_n);
endinterface

// File: rtl/router_input_ctrl.sv
// rtl/router_input_ctrl.sv - per-input address capture and IDLE/ADDR/FWD/DROP sequencing
module router_input_ctrl
  import router_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_din,
  input  logic              i_frame_n,
  input  logic              i_valid_n,
  input  logic              i_grant,
  output logic              o_req,
  output logic [ADDR_W-1:0] o_dest,
  output logic              o_rel
);

  in_state_e r_state;
  logic [1:0] r_cnt;
  logic [2:0] r_addr;
  logic       r_frame_hi;

  // Request is raised on the cycle carrying address bit 3, using that bit live.
  assign o_req  = (r_state == ADDR) && (r_cnt == 2'd3) && !i_frame_n;
  assign o_dest = {i_din, r_addr};
  assign o_rel  = (r_state == FWD) && i_frame_n && !i_valid_n;

  // r_frame_hi starts low so a frame already in progress at reset release is ignored.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_cnt      <= 2'd0;
      r_addr     <= 3'd0;
      r_frame_hi <= 1'b0;
    end else begin
      r_frame_hi <= i_frame_n;
      case (r_state)
        IDLE: begin
          if (!i_frame_n && r_frame_hi) begin
            r_addr  <= {2'b00, i_din};
            r_cnt   <= 2'd1;
            r_state <= ADDR;
          end
        end
        ADDR: begin
          if (i_frame_n) begin
            r_state <= IDLE;
          end else if (r_cnt == 2'd3) begin
            r_state <= i_grant ? FWD : DROP;
          end else begin
            r_addr[r_cnt] <= i_din;
            r_cnt         <= r_cnt + 2'd1;
          end
        end
        FWD, DROP: begin
          if (i_frame_n && !i_valid_n) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/router_16x16.sv
// rtl/router_16x16.sv - 16-port serial packet switch: per-output round-robin arbitration and registered crossbar
module router_16x16
  import router_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  router_16x16_if.slave bus
);

  logic [NPORTS-1:0] w_req;
  logic [NPORTS-1:0] w_gnt;
  logic [NPORTS-1:0] w_rel;
  logic [ADDR_W-1:0] w_dest  [NPORTS];
  logic [NPORTS-1:0] w_req_m [NPORTS];
  logic [ADDR_W:0]   w_pick  [NPORTS];

  logic [NPORTS-1:0] r_busy;
  logic [NPORTS-1:0] r_dout;
  logic [NPORTS-1:0] r_valido_n;
  logic [NPORTS-1:0] r_frameo_n;
  logic [ADDR_W-1:0] r_owner [NPORTS];
  logic [ADDR_W-1:0] r_ptr   [NPORTS];

  for (genvar g = 0; g < NPORTS; g++) begin : g_in
    router_input_ctrl u_in (
      .clk       (clk),
      .reset_n   (reset_n),
      .i_din     (bus.din[g]),
      .i_frame_n (bus.frame_n[g]),
      .i_valid_n (bus.valid_n[g]),
      .i_grant   (w_gnt[g]),
      .o_req     (w_req[g]),
      .o_dest    (w_dest[g]),
      .o_rel     (w_rel[g])
    );
  end

  // A busy output grants nobody; losers of the pick fall into DROP immediately.
  always_comb begin
    w_gnt = '0;
    for (int o = 0; o < NPORTS; o++) begin
      for (int i = 0; i < NPORTS; i++) begin
        w_req_m[o][i] = w_req[i] && (w_dest[i] == ADDR_W'(o));
      end
      w_pick[o] = rr_pick(w_req_m[o], r_ptr[o]);
      if (!r_busy[o] && w_pick[o][ADDR_W]) w_gnt[w_pick[o][ADDR_W-1:0]] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_busy     <= '0;
      r_dout     <= '0;
      r_valido_n <= '1;
      r_frameo_n <= '1;
      for (int o = 0; o < NPORTS; o++) begin
        r_owner[o] <= '0;
        r_ptr[o]   <= '0;
      end
    end else begin
      for (int o = 0; o < NPORTS; o++) begin
        if (r_busy[o]) begin
          r_dout[o]     <= bus.din[r_owner[o]];
          r_valido_n[o] <= bus.valid_n[r_owner[o]];
          r_frameo_n[o] <= bus.frame_n[r_owner[o]];
          if (w_rel[r_owner[o]]) r_busy[o] <= 1'b0;
        end else begin
          r_dout[o]     <= 1'b0;
          r_valido_n[o] <= 1'b1;
          r_frameo_n[o] <= 1'b1;
          if (w_pick[o][ADDR_W]) begin
            r_busy[o]  <= 1'b1;
            r_owner[o] <= w_pick[o][ADDR_W-1:0];
            r_ptr[o]   <= w_pick[o][ADDR_W-1:0] + 1'b1;
          end
        end
      end
    end
  end

  assign bus.dout     = r_dout;
  assign bus.valido_n = r_valido_n;
  assign bus.frameo_n = r_frameo_n;

endmodule

// File: tb/tb_router_16x16.sv
// tb/tb_router_16x16.sv - directed self-checking bench for router_16x16
module tb_router_16x16;
  import router_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  router_16x16_if bus();

  router_16x16 dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [2:0]   stim  [NPORTS][0:255];
  int           stim_len [NPORTS];
  int           pk_s  [NPORTS][0:3];
  int           pk_e  [NPORTS][0:3];
  int           pk_n  [NPORTS];
  logic [2:0]   trace [NPORTS][0:255];
  logic [127:0] rx_bits [NPORTS];
  int           rx_n [NPORTS];
  int           pkts [NPORTS];
  int           act  [NPORTS];
  int           first_act [NPORTS];
  bit           mon_on = 1'b0;
  int           start_cyc = 0;
  logic [127:0] pm_data [NPORTS];
  int           pm_nb   [NPORTS];

  always @(posedge clk) begin
    #1;
    if (mon_on) begin
      for (int o = 0; o < NPORTS; o++) begin
        if (cyc - start_cyc < 256) trace[o][cyc - start_cyc] = {bus.frameo_n[o], bus.valido_n[o], bus.dout[o]};
        if (!bus.frameo_n[o] || !bus.valido_n[o]) begin
          act[o]++;
          if (first_act[o] < 0) first_act[o] = cyc - start_cyc;
        end
        if (!bus.valido_n[o]) begin
          if (rx_n[o] < 128) rx_bits[o][rx_n[o]] = bus.dout[o];
          rx_n[o]++;
          if (bus.frameo_n[o]) pkts[o]++;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear();
    for (int p = 0; p < NPORTS; p++) begin
      stim_len[p]  = 1;
      stim[p][0]   = 3'b110;
      pk_n[p]      = 0;
      rx_bits[p]   = '0;
      rx_n[p]      = 0;
      pkts[p]      = 0;
      act[p]       = 0;
      first_act[p] = -1;
      for (int c = 0; c < 256; c++) trace[p][c] = 3'b110;
    end
  endtask

  task automatic push(input int p, input logic [2:0] v);
    stim[p][stim_len[p]] = v;
    stim_len[p]++;
  endtask

  task automatic add_idle(input int p, input int n);
    for (int k = 0; k < n; k++) push(p, 3'b110);
  endtask

  // {frame_n, valid_n, din}; gaps[k] inserts one valid_n=1 cycle before payload bit k.
  task automatic add_pkt(input int p, input int addr, input int npad, input int nbits,
                         input logic [127:0] data, input logic [127:0] gaps);
    for (int k = 0; k < 4; k++) push(p, {1'b0, 1'b1, addr[k]});
    pk_s[p][pk_n[p]] = stim_len[p];
    for (int k = 0; k < npad; k++) push(p, 3'b010);
    for (int k = 0; k < nbits; k++) begin
      if (gaps[k]) push(p, 3'b010);
      push(p, {(k == nbits - 1), 1'b0, data[k]});
    end
    pk_e[p][pk_n[p]] = stim_len[p] - 1;
    pk_n[p]++;
    push(p, 3'b110);
  endtask

  task automatic run(input int rst_at);
    int n;
    n = 0;
    for (int p = 0; p < NPORTS; p++) if (stim_len[p] > n) n = stim_len[p];
    n = n + 4;
    @(negedge clk);
    start_cyc = cyc;
    mon_on = 1'b1;
    for (int c = 0; c < n; c++) begin
      if (c > 0) @(negedge clk);
      for (int p = 0; p < NPORTS; p++)
        {bus.frame_n[p], bus.valid_n[p], bus.din[p]} = (c < stim_len[p]) ? stim[p][c] : 3'b110;
      if (c == rst_at + 1) reset_n = 1'b1;
      if (c == rst_at) begin
        #1 reset_n = 1'b0;
        #1;
        chk("mid_rst_dout", bus.dout, 128'h0);
        chk("mid_rst_valido_n", bus.valido_n, 128'hFFFF);
        chk("mid_rst_frameo_n", bus.frameo_n, 128'hFFFF);
      end
    end
    @(negedge clk);
    mon_on = 1'b0;
  endtask

  initial begin
    int s;
    int errs;
    logic [127:0] m;
    logic [2:0] ex;
    bit in_win;

    reset_n = 1'b0;
    bus.din = '0;
    bus.frame_n = '1;
    bus.valid_n = '1;
    repeat (3) @(negedge clk);
    chk("rst_dout", bus.dout, 128'h0);
    chk("rst_valido_n", bus.valido_n, 128'hFFFF);
    chk("rst_frameo_n", bus.frameo_n, 128'hFFFF);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_frameo_n", bus.frameo_n, 128'hFFFF);

    // Single packet: input 3 -> output 7, payload A5
    clear();
    add_pkt(3, 7, 5, 8, 128'hA5, 128'h0);
    run(-1);
    chk("single_data", rx_bits[7], 128'hA5);
    chk("single_nbits", rx_n[7], 8);
    chk("single_active_cycles", act[7], 13);
    chk("single_first_active", first_act[7], 6);
    chk("single_pkts", pkts[7], 1);
    s = 0;
    for (int o = 0; o < NPORTS; o++) if (o != 7) s += act[o];
    chk("single_crosstalk", s, 0);

    // Reset asserted while input 3 is mid-packet
    clear();
    add_pkt(3, 7, 5, 32, 128'hDEADBEEF, 128'h0);
    run(12);
    chk("mid_rst_was_active", trace[7][12][2], 1'b0);
    errs = 0;
    for (int o = 0; o < NPORTS; o++)
      for (int c = 13; c < 256; c++) if (trace[o][c] !== 3'b110) errs++;
    chk("mid_rst_quiet_after", errs, 0);
    chk("mid_rst_no_pkt", pkts[7], 0);

    // Contention for output 9: pointer 0 -> input 2 wins
    clear();
    add_pkt(2, 9, 5, 8, 128'h3C, 128'h0);
    add_pkt(5, 9, 5, 8, 128'hC3, 128'h0);
    run(-1);
    chk("cont1_data", rx_bits[9], 128'h3C);
    chk("cont1_nbits", rx_n[9], 8);
    chk("cont1_pkts", pkts[9], 1);

    // Same pair again: pointer 3 -> input 5 wins
    clear();
    add_pkt(2, 9, 5, 8, 128'h3C, 128'h0);
    add_pkt(5, 9, 5, 8, 128'hC3, 128'h0);
    run(-1);
    chk("cont2_data", rx_bits[9], 128'hC3);
    chk("cont2_nbits", rx_n[9], 8);

    // Busy output 4: input 6's overlapping packet dropped, later one delivered
    clear();
    add_pkt(1, 4, 5, 16, 128'hBEEF, 128'h0);
    add_idle(6, 4);
    add_pkt(6, 4, 5, 8, 128'h5A, 128'h0);
    add_idle(6, 27 - stim_len[6]);
    add_pkt(6, 4, 5, 8, 128'h96, 128'h0);
    run(-1);
    chk("busy_data", rx_bits[4], 128'h96BEEF);
    chk("busy_nbits", rx_n[4], 24);
    chk("busy_pkts", pkts[4], 2);
    chk("busy_active_cycles", act[4], 34);

    // Full permutation: input i -> output 15-i
    clear();
    for (int i = 0; i < NPORTS; i++) begin
      pm_nb[i] = $urandom_range(1, 16);
      m = '1;
      if (pm_nb[i] < 16) m = (128'd1 << (pm_nb[i] * 8)) - 128'd1;
      pm_data[i] = {$urandom(), $urandom(), $urandom(), $urandom()} & m;
      add_pkt(i, 15 - i, 5, pm_nb[i] * 8, pm_data[i], 128'h0);
    end
    run(-1);
    for (int i = 0; i < NPORTS; i++) begin
      chk($sformatf("perm_data_in%0d", i), rx_bits[15 - i], pm_data[i]);
      chk($sformatf("perm_nbits_in%0d", i), rx_n[15 - i], pm_nb[i] * 8);
    end

    // Gaps and back-to-back packets on input 0 -> output 12
    clear();
    add_pkt(0, 12, 5, 8, 128'hE7, 128'h24);
    add_pkt(0, 12, 5, 8, 128'h18, 128'h10);
    run(-1);
    errs = 0;
    for (int c = 0; c < stim_len[0]; c++) begin
      in_win = 1'b0;
      for (int k = 0; k < pk_n[0]; k++) if (c >= pk_s[0][k] && c <= pk_e[0][k]) in_win = 1'b1;
      ex = in_win ? stim[0][c] : 3'b110;
      if (trace[12][c + 1] !== ex) errs++;
    end
    chk("gap_trace_errors", errs, 0);
    chk("gap_data", rx_bits[12], 128'h18E7);
    chk("gap_pkts", pkts[12], 2);
    chk("gap_active_cycles", act[12], 29);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/router_16x16.md
# router_16x16

Sixteen-port serial packet switch at the core of the router block. Each of 16 input ports receives bit-serial packets framed by `frame_n`/`valid_n`. A 4-bit destination address leads each packet. The switch forwards the packet's cycles to the addressed output port with one clock of latency, arbitrating round-robin when several inputs target the same output.

## Interface
- No parameters; port count 16 and address width 4 are fixed constants.
- `clk`  in  1  single clock, all logic on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `din`  in  16  serial data, bit i = input port i.
- `frame_n`  in  16  active-low frame per input; low for the whole packet, high on the last payload bit.
- `valid_n`  in  16  active-low payload-bit qualifier per input.
- `dout`  out  16  serial data per output port.
- `valido_n`  out  16  active-low payload qualifier per output.
- `frameo_n`  out  16  active-low frame per output.

## Operation
- Input packet format, per port:
  - Address phase: 4 cycles, `frame_n`=0, `valid_n`=1, `din` = destination address, LSB first. The first cycle is the one where `frame_n` is first sampled low in IDLE.
  - Pad phase: ≥1 cycle (nominally 5), `frame_n`=0, `valid_n`=1.
  - Payload: bits with `valid_n`=0. Cycles with `valid_n`=1 inside the frame are gaps and are forwarded as-is. The last payload bit has `frame_n`=1, `valid_n`=0.
- Input FSM states:
  - IDLE: wait for `frame_n`=0.
  - ADDR: counts address bits 0..3. If `frame_n` returns high mid-address, the packet is aborted and the FSM returns to IDLE.
  - FWD: connected to an output.
  - DROP: ignore the input until the last bit, then IDLE.
- Arbitration:
  - Happens on the edge sampling address bit 3, using the complete address including that bit.
  - If the target output is free, the input is granted and moves to FWD; otherwise it moves to DROP. A packet never waits.
  - Simultaneous requests to one free output: round-robin. The winner is the first requester at or after the output's pointer, scanning upward mod 16. The pointer then becomes winner+1 mod 16; pointers reset to 0.
- While in FWD, each cycle the output registers the connected input: `dout`←`din`, `valido_n`←`valid_n`, `frameo_n`←`frame_n`.
- Release: the cycle with `frame_n`=1 and `valid_n`=0 is forwarded, then input and output return to free/IDLE. The output is requestable again on the following edge.
- Idle output: `dout`=0, `valido_n`=1, `frameo_n`=1.
- Independent input/output pairs operate fully concurrently.

## Timing
- Reset (async assert): all outputs idle (`dout`=0, `valido_n`=1, `frameo_n`=1), all input FSMs IDLE, all outputs free, pointers 0.
- Latency: an input cycle t after grant appears on the output at cycle t+1. The output's first frame cycle is the registered first pad cycle; address cycles are not forwarded.
- Minimum gap between packets on one input: 1 cycle with `frame_n`=1.
- A release and a new grant on the same output never occur on the same edge.
- Reset asserted mid-packet: connections are dropped immediately. After deassertion, inputs still mid-frame stay IDLE until `frame_n` is high, then low again.

## Structure
- Shared package `router_pkg`:
  - constants `NPORTS`=16, `ADDR_W`=4
  - input-state enum {IDLE, ADDR, FWD, DROP}
- Sub-module `router_input_ctrl`, instantiated ×16: address shift register, bit counter, FSM, request and destination outputs.
- Top level: per-output busy flags, owner index, round-robin arbiters and the output register crossbar.

## Test plan
- Reset: assert `reset_n`=0 mid-traffic -> all `frameo_n`/`valido_n` = 16'hFFFF and `dout`=0 within the same cycle; no output activity after release until new frames arrive.
- Single packet: input 3 → address 7 (bits 1,1,1,0), 5 pad cycles, payload 8'hA5 LSB first -> output 7 holds `frameo_n`=0 for 5 pad plus 8 payload cycles starting one cycle after the pad begins. `valido_n`=0 for exactly 8 cycles, bits 1,0,1,0,0,1,0,1, `frameo_n`=1 on the 8th; all other outputs idle.
- Full permutation: input i → output 15−i simultaneously, random 1–16-byte payloads -> every output delivers its own payload intact, no cross-talk.
- Contention: inputs 2 and 5 both address output 9 on the same cycle after reset -> input 2 granted and delivered, input 5 dropped. Repeat the same pair -> input 5 wins (pointer now 3).
- Busy output: input 1 sending to output 4; input 6 addresses 4 mid-packet -> input 6's packet dropped entirely. A packet from input 6 to output 4 after input 1's last bit is delivered.
- Gaps and back-to-back: payload with `valid_n` gaps plus consecutive packets separated by one idle cycle -> gaps reproduced one cycle later, both packets delivered.
